// File: rtl/piso_serializer_if.sv
// Handshake and serial-line bundle for piso_serializer.
//   master : upstream word source; drives data_in/load_valid and observes the rest
//   slave  : the serializer itself
// Signals:
//   data_in    [WIDTH] parallel word
//   load_valid         data_in valid, requests transfer
//   load_ready         serializer can accept a word this cycle
//   dout               serial bit stream (registered)
//   bit_valid          dout carries a frame bit
//   busy               frame in progress
//   frame_done         pulse on the last bit of a frame
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             dout;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output data_in, load_valid,
    input  load_ready, dout, bit_valid, busy, frame_done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, dout, bit_valid, busy, frame_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage feeding the serial sequence detectors.
// A WIDTH-bit word is accepted on load_valid && load_ready and driven onto
// dout one bit per clock, starting the cycle after the accepting edge.
// Back-to-back frames are gapless: load_ready is raised on the last bit so
// the next word can be taken on the edge that ends the current frame.
//
// Parameters:
//   WIDTH      word length (2..32)
//   MSB_FIRST  1: bit WIDTH-1 first (shift left); 0: bit 0 first (shift right)
//   IDLE_LEVEL level held on dout between frames
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    piso_serializer_if.slave (data_in, load_valid, load_ready, dout,
//          bit_valid, busy, frame_done)
// Optional build macro:
//   PISO_PARITY_EN  appends an even-parity bit (XOR of the captured word)
//                   after the data bits; frame_done then marks the parity bit.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  piso_serializer_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   sreg_next;
  logic [CNT_W-1:0]   cnt;
  logic               dout_q;
  logic               bit_valid_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               load_ready_q;
  logic               accept;
  logic               last_data;
`ifdef PISO_PARITY_EN
  logic               parity_q;
`endif

  // The bit currently on dout is always the head of sreg; shifting exposes
  // the next one.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    else           return w[0];
  endfunction

  always_comb begin
    sreg_next = shift_word(sreg);
    accept    = bus.load_valid && load_ready_q;
    last_data = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      dout_q       <= IDLE_LEVEL;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else if (accept) begin
      // load_ready is only high in IDLE, on the final bit, or in PARITY,
      // so every accept starts a fresh frame from any of those points.
      state        <= SHIFT;
      sreg         <= bus.data_in;
      cnt          <= '0;
      dout_q       <= head_bit(bus.data_in);
      bit_valid_q  <= 1'b1;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q     <= ^bus.data_in;
`endif
    end else begin
      case (state)
        IDLE: begin
        end
        SHIFT: begin
          if (last_data) begin
`ifdef PISO_PARITY_EN
            state        <= PARITY;
            dout_q       <= parity_q;
            frame_done_q <= 1'b1;
            load_ready_q <= 1'b1;
`else
            state        <= IDLE;
            dout_q       <= IDLE_LEVEL;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            load_ready_q <= 1'b1;
`endif
          end else begin
            cnt    <= cnt + CNT_W'(1);
            sreg   <= sreg_next;
            dout_q <= head_bit(sreg_next);
`ifndef PISO_PARITY_EN
            // Outputs are registered, so the last-bit flags are set one
            // edge early, together with the last bit itself.
            if (cnt == CNT_W'(WIDTH - 2)) begin
              frame_done_q <= 1'b1;
              load_ready_q <= 1'b1;
            end
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state        <= IDLE;
          dout_q       <= IDLE_LEVEL;
          bit_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
          load_ready_q <= 1'b1;
        end
`endif
        default: begin
          state        <= IDLE;
          dout_q       <= IDLE_LEVEL;
          bit_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.load_ready = load_ready_q;

endmodule
